// File: rtl/nibble_exec.sv
// Decode/execute stage of the 4-bit processor: fetch/exec/addr sequencer,
// accumulator, carry/zero flags and output register. Drives the upstream PC/fetch block.
package nibble_exec_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LIT = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_IN  = 4'h6;
  localparam logic [3:0] OP_OUT = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JNZ = 4'hC;
  localparam logic [3:0] OP_CMP = 4'hD;
  localparam logic [3:0] OP_XOR = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
endpackage

// Combinational datapath for one EXEC cycle; opcodes it does not know pass
// A, C and Z through untouched.
module nibble_alu
  import nibble_exec_pkg::*;
(
  input  logic [3:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] din,
  input  logic       c_in,
  input  logic       z_in,
  output logic [3:0] a_nxt,
  output logic       c_nxt,
  output logic       z_nxt,
  output logic       out_wr
);
  logic [4:0] sum;
  logic [3:0] diff;
  logic       no_borrow;

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = a - b;
    no_borrow = (a >= b);
    a_nxt     = a;
    c_nxt     = c_in;
    z_nxt     = z_in;
    out_wr    = 1'b0;
    case (op)
      OP_LIT: a_nxt = b;
      OP_ADD: begin
        a_nxt = sum[3:0];
        c_nxt = sum[4];
        z_nxt = (sum[3:0] == 4'h0);
      end
      OP_SUB: begin
        a_nxt = diff;
        c_nxt = no_borrow;
        z_nxt = (diff == 4'h0);
      end
      OP_AND: begin
        a_nxt = a & b;
        z_nxt = ((a & b) == 4'h0);
      end
      OP_OR: begin
        a_nxt = a | b;
        z_nxt = ((a | b) == 4'h0);
      end
      OP_XOR: begin
        a_nxt = a ^ b;
        z_nxt = ((a ^ b) == 4'h0);
      end
      OP_IN: begin
        a_nxt = din;
        z_nxt = (din == 4'h0);
      end
      OP_OUT: out_wr = 1'b1;
      // compare sets flags exactly like SUB but keeps A
      OP_CMP: begin
        c_nxt = no_borrow;
        z_nxt = (diff == 4'h0);
      end
      default: ;
    endcase
  end
endmodule

module nibble_exec
  import nibble_exec_pkg::*;
#(
  parameter logic [3:0] RST_ACC = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  instr,
  input  logic [3:0]  oprnd,
  input  logic [7:0]  program_byte,
  input  logic [3:0]  data_in,
  output logic        pc_en,
  output logic        fetch_en,
  output logic        pc_load,
  output logic [11:0] pc_d,
  output logic [3:0]  accu,
  output logic        c_flag,
  output logic        z_flag,
  output logic [3:0]  out_reg,
  output logic        phase,
  output logic        halted
);
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_ADDR, S_HALT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  acc_q, out_q, addr_hi_q;
  logic        c_q, z_q;
  logic [2:0]  jcond_q;
  logic [11:0] pc_d_q;
  logic        exec_go, jump_latch, is_jump, jump_taken;
  logic [3:0]  alu_a;
  logic        alu_c, alu_z, alu_out_wr;

  nibble_alu u_alu (
    .op     (instr),
    .a      (acc_q),
    .b      (oprnd),
    .din    (data_in),
    .c_in   (c_q),
    .z_in   (z_q),
    .a_nxt  (alu_a),
    .c_nxt  (alu_c),
    .z_nxt  (alu_z),
    .out_wr (alu_out_wr)
  );

  assign is_jump = (instr >= OP_JMP) && (instr <= OP_JNZ);

  // The jump opcode's low bits are kept because instr already shows the
  // address byte by the time ADDR evaluates the condition.
  always_comb begin
    case (jcond_q)
      3'd0:    jump_taken = 1'b1;
      3'd1:    jump_taken = c_q;
      3'd2:    jump_taken = ~c_q;
      3'd3:    jump_taken = z_q;
      3'd4:    jump_taken = ~z_q;
      default: jump_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    pc_en      = 1'b0;
    fetch_en   = 1'b0;
    pc_load    = 1'b0;
    exec_go    = 1'b0;
    jump_latch = 1'b0;
    if (!reset && enable) begin
      case (state)
        S_FETCH: begin
          pc_en     = 1'b1;
          fetch_en  = 1'b1;
          state_nxt = S_EXEC;
        end
        S_EXEC: begin
          exec_go = 1'b1;
          if (is_jump) begin
            jump_latch = 1'b1;
            pc_en      = 1'b1;
            fetch_en   = 1'b1;
            state_nxt  = S_ADDR;
          end else if (instr == OP_HLT) begin
            state_nxt = S_HALT;
          end else begin
            state_nxt = S_FETCH;
          end
        end
        // not taken: the counter already stepped past the address byte
        S_ADDR: begin
          pc_load   = jump_taken;
          state_nxt = S_FETCH;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      acc_q     <= RST_ACC;
      out_q     <= RST_ACC;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      addr_hi_q <= 4'h0;
      jcond_q   <= 3'd0;
      pc_d_q    <= 12'h000;
    end else begin
      state <= state_nxt;
      if (exec_go) begin
        acc_q <= alu_a;
        c_q   <= alu_c;
        z_q   <= alu_z;
        if (alu_out_wr) out_q <= acc_q;
      end
      if (jump_latch) begin
        addr_hi_q <= oprnd;
        jcond_q   <= instr[2:0];
      end
      if (pc_load) pc_d_q <= {addr_hi_q, program_byte};
    end
  end

  assign pc_d    = pc_load ? {addr_hi_q, program_byte} : pc_d_q;
  assign accu    = acc_q;
  assign c_flag  = c_q;
  assign z_flag  = z_q;
  assign out_reg = out_q;
  assign phase   = (state == S_EXEC) || (state == S_ADDR);
  assign halted  = (state == S_HALT);
endmodule

// File: tb/tb_nibble_exec.sv
// Self-checking bench for nibble_exec: a reference model pushes expected
// register state per instruction; a retire monitor pops it when phase falls.
module tb_nibble_exec;
  logic        clk = 1'b0;
  logic        reset, enable;
  logic [3:0]  instr, oprnd, data_in;
  logic [7:0]  program_byte;
  logic        pc_en, fetch_en, pc_load;
  logic [11:0] pc_d;
  logic [3:0]  accu, out_reg;
  logic        c_flag, z_flag, phase, halted;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] acc;
    logic       c;
    logic       z;
    logic [3:0] out;
  } exp_t;
  exp_t sb[$];

  logic [3:0] m_acc, m_out;
  logic       m_c, m_z;

  nibble_exec #(.RST_ACC(4'h0)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .instr        (instr),
    .oprnd        (oprnd),
    .program_byte (program_byte),
    .data_in      (data_in),
    .pc_en        (pc_en),
    .fetch_en     (fetch_en),
    .pc_load      (pc_load),
    .pc_d         (pc_d),
    .accu         (accu),
    .c_flag       (c_flag),
    .z_flag       (z_flag),
    .out_reg      (out_reg),
    .phase        (phase),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_acc = 4'h0; m_out = 4'h0; m_c = 1'b0; m_z = 1'b0;
  endtask

  // Reference behaviour of one instruction, derived from the ISA description.
  task automatic model_push(input logic [3:0] op, input logic [3:0] opr);
    logic [4:0] s;
    logic [3:0] d;
    case (op)
      4'h1: m_acc = opr;
      4'h2: begin
        s = {1'b0, m_acc} + {1'b0, opr};
        m_c = s[4]; m_acc = s[3:0]; m_z = (m_acc == 4'h0);
      end
      4'h3: begin
        m_c = (m_acc >= opr); m_acc = m_acc - opr; m_z = (m_acc == 4'h0);
      end
      4'h4: begin m_acc = m_acc & opr; m_z = (m_acc == 4'h0); end
      4'h5: begin m_acc = m_acc | opr; m_z = (m_acc == 4'h0); end
      4'hE: begin m_acc = m_acc ^ opr; m_z = (m_acc == 4'h0); end
      4'h6: begin m_acc = data_in; m_z = (m_acc == 4'h0); end
      4'h7: m_out = m_acc;
      4'hD: begin
        d = m_acc - opr; m_c = (m_acc >= opr); m_z = (d == 4'h0);
      end
      default: ;
    endcase
    sb.push_back('{m_acc, m_c, m_z, m_out});
  endtask

  // Drives one instruction from FETCH back to FETCH; no checking here.
  task automatic drive_instr(input logic [3:0] op, input logic [3:0] opr,
                             input logic [7:0] addr_byte);
    instr = op; oprnd = opr; program_byte = {op, opr};
    model_push(op, opr);
    tick();
    if (op >= 4'h8 && op <= 4'hC) begin
      program_byte = addr_byte;
      tick();
    end
    tick();
  endtask

  // Retire monitor: an instruction ends when phase falls outside reset.
  logic prev_phase = 1'b0;
  logic prev_rst   = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (prev_phase === 1'b1 && phase === 1'b0 && prev_rst === 1'b0) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL retire_unexpected: acc=%h c=%b z=%b out=%h with nothing pending",
                 accu, c_flag, z_flag, out_reg);
      end else begin
        e = sb.pop_front();
        if ({accu, c_flag, z_flag, out_reg} !== {e.acc, e.c, e.z, e.out}) begin
          n_fail++;
          $display("FAIL retire_regs: got acc=%h c=%b z=%b out=%h, expected acc=%h c=%b z=%b out=%h",
                   accu, c_flag, z_flag, out_reg, e.acc, e.c, e.z, e.out);
        end
      end
    end
    prev_phase = phase;
    prev_rst   = reset;
  end

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; instr = 4'h0; oprnd = 4'h0;
    program_byte = 8'h00; data_in = 4'h0;
    model_reset();
    repeat (3) tick();
    n_checks++;
    if ({accu, c_flag, z_flag, out_reg, halted, phase} !== {4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_regs: acc=%h c=%b z=%b out=%h halted=%b phase=%b, expected all zero",
               accu, c_flag, z_flag, out_reg, halted, phase);
    end
    n_checks++;
    if ({pc_en, fetch_en, pc_load, pc_d} !== {3'b000, 12'h000}) begin
      n_fail++;
      $display("FAIL reset_strobes: en=%b fe=%b ld=%b pc_d=%h, expected 0 0 0 000",
               pc_en, fetch_en, pc_load, pc_d);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({pc_en, fetch_en, pc_load} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_release_fetch: strobes=%b expected 110", {pc_en, fetch_en, pc_load});
    end
  endtask

  task automatic test_add();
    instr = 4'h1; oprnd = 4'h9; program_byte = 8'h19;
    model_push(4'h1, 4'h9);
    n_checks++;
    if ({pc_en, fetch_en, phase} !== 3'b110) begin
      n_fail++;
      $display("FAIL add_fetch_strobes: en/fe/phase=%b expected 110", {pc_en, fetch_en, phase});
    end
    tick();
    n_checks++;
    if ({pc_en, fetch_en, pc_load, phase, accu} !== {4'b0001, 4'h0}) begin
      n_fail++;
      $display("FAIL add_exec_strobes: en/fe/ld/phase=%b acc=%h expected 0001 acc=0",
               {pc_en, fetch_en, pc_load, phase}, accu);
    end
    tick();
    n_checks++;
    if ({phase, accu} !== {1'b0, 4'h9}) begin
      n_fail++;
      $display("FAIL lit_two_cycle: phase=%b acc=%h expected phase=0 acc=9", phase, accu);
    end
    drive_instr(4'h2, 4'h9, 8'h00);
    n_checks++;
    if ({accu, c_flag, z_flag} !== {4'h2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL add_carry: acc=%h c=%b z=%b expected acc=2 c=1 z=0", accu, c_flag, z_flag);
    end
  endtask

  task automatic test_sub_cmp();
    drive_instr(4'h1, 4'h3, 8'h00);
    drive_instr(4'h3, 4'h3, 8'h00);
    n_checks++;
    if ({accu, c_flag, z_flag} !== {4'h0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_zero: acc=%h c=%b z=%b expected acc=0 c=1 z=1", accu, c_flag, z_flag);
    end
    drive_instr(4'hD, 4'h5, 8'h00);
    n_checks++;
    if ({accu, c_flag, z_flag} !== {4'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL cmp_borrow: acc=%h c=%b z=%b expected acc=0 c=0 z=0", accu, c_flag, z_flag);
    end
  endtask

  task automatic test_jz_taken();
    drive_instr(4'h4, 4'h0, 8'h00);   // AND 0 -> Z=1
    instr = 4'hB; oprnd = 4'h4; program_byte = 8'hB4;
    model_push(4'hB, 4'h4);
    tick();
    n_checks++;
    if ({pc_en, fetch_en, pc_load} !== 3'b110) begin
      n_fail++;
      $display("FAIL jz_exec_fetch: strobes=%b expected 110", {pc_en, fetch_en, pc_load});
    end
    program_byte = 8'h21;
    tick();
    n_checks++;
    if ({pc_en, fetch_en, pc_load, pc_d} !== {3'b001, 12'h421}) begin
      n_fail++;
      $display("FAIL jz_load: strobes=%b pc_d=%h expected 001 pc_d=421",
               {pc_en, fetch_en, pc_load}, pc_d);
    end
    tick();
    program_byte = 8'h99;
    #1;
    n_checks++;
    if ({pc_load, phase, pc_en, pc_d} !== {3'b001, 12'h421}) begin
      n_fail++;
      $display("FAIL jz_after: ld/phase/en=%b pc_d=%h expected 001 pc_d=421 held",
               {pc_load, phase, pc_en}, pc_d);
    end
  endtask

  task automatic test_jnz_not_taken();
    int loads = 0;
    instr = 4'hC; oprnd = 4'h7; program_byte = 8'hC7;
    model_push(4'hC, 4'h7);
    for (int i = 0; i < 3; i++) begin
      if (pc_load !== 1'b0) loads++;
      if (i == 1) program_byte = 8'h55;
      tick();
    end
    n_checks++;
    if ({loads[3:0], phase, c_flag, z_flag} !== {4'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL jnz_not_taken: loads=%0d phase=%b c=%b z=%b expected 0 0 0 1",
               loads, phase, c_flag, z_flag);
    end
  endtask

  task automatic test_io_halt();
    int bad = 0;
    data_in = 4'hA;
    drive_instr(4'h6, 4'h0, 8'h00);
    drive_instr(4'h7, 4'h0, 8'h00);
    n_checks++;
    if ({out_reg, accu, z_flag} !== {4'hA, 4'hA, 1'b0}) begin
      n_fail++;
      $display("FAIL in_out: out=%h acc=%h z=%b expected out=a acc=a z=0", out_reg, accu, z_flag);
    end
    drive_instr(4'hF, 4'h0, 8'h00);
    n_checks++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL hlt_enter: halted=%b expected 1", halted);
    end
    for (int i = 0; i < 10; i++) begin
      enable = 1'($urandom_range(0, 1));
      #1;
      if ({pc_en, fetch_en, pc_load, halted} !== 4'b0001) bad++;
      tick();
    end
    enable = 1'b1;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hlt_stays: %0d cycles with strobes or halted wrong, expected 0", bad);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({halted, accu, out_reg, pc_en} !== {1'b0, 4'h0, 4'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL hlt_reset_exit: halted=%b acc=%h out=%h en=%b expected 0 0 0 1",
               halted, accu, out_reg, pc_en);
    end
  endtask

  task automatic test_enable_stall();
    int moved = 0;
    enable = 1'b0;
    #1;
    n_checks++;
    if ({pc_en, fetch_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL en_low_fetch: en/fe=%b expected 00", {pc_en, fetch_en});
    end
    tick();
    enable = 1'b1;
    #1;
    n_checks++;
    if ({phase, pc_en, fetch_en} !== 3'b011) begin
      n_fail++;
      $display("FAIL en_resume_fetch: phase/en/fe=%b expected 011", {phase, pc_en, fetch_en});
    end
    drive_instr(4'h1, 4'h5, 8'h00);
    instr = 4'h2; oprnd = 4'h7; program_byte = 8'h27;
    model_push(4'h2, 4'h7);
    tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ({accu, phase, pc_en} !== {4'h5, 1'b1, 1'b0}) moved++;
    end
    n_checks++;
    if (moved != 0) begin
      n_fail++;
      $display("FAIL en_stall_exec: %0d stalled cycles changed state, expected 0", moved);
    end
    enable = 1'b1;
    tick();
    n_checks++;
    if ({accu, c_flag, z_flag, phase} !== {4'hC, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL en_stall_complete: acc=%h c=%b z=%b phase=%b expected c 0 0 0",
               accu, c_flag, z_flag, phase);
    end
  endtask

  task automatic test_reset_in_addr();
    instr = 4'h8; oprnd = 4'h3; program_byte = 8'h83;
    tick();
    program_byte = 8'h77;
    tick();
    n_checks++;
    if ({phase, pc_load, pc_d} !== {2'b11, 12'h377}) begin
      n_fail++;
      $display("FAIL jmp_addr: phase/ld=%b pc_d=%h expected 11 pc_d=377", {phase, pc_load}, pc_d);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({pc_en, fetch_en, pc_load} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_addr_no_load: strobes=%b expected 000", {pc_en, fetch_en, pc_load});
    end
    tick();
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({phase, pc_en, accu, c_flag, z_flag, out_reg, pc_d} !==
        {2'b01, 4'h0, 2'b00, 4'h0, 12'h000}) begin
      n_fail++;
      $display("FAIL rst_addr_state: phase=%b en=%b acc=%h c=%b z=%b out=%h pc_d=%h expected 0 1 0 0 0 0 000",
               phase, pc_en, accu, c_flag, z_flag, out_reg, pc_d);
    end
    drive_instr(4'h1, 4'h1, 8'h00);
    drive_instr(4'hE, 4'h1, 8'h00);   // XOR to zero -> Z=1
    n_checks++;
    if ({accu, z_flag} !== {4'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL xor_after_reset: acc=%h z=%b expected 0 1", accu, z_flag);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_cmp();
    test_jz_taken();
    test_jnz_not_taken();
    test_io_halt();
    test_enable_stall();
    test_reset_in_addr();
    repeat (2) tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/nibble_exec.md
# nibble_exec

Decode/execute stage of the 4-bit processor, directly downstream of the program-counter/ROM/fetch-register block. It consumes the fetched `instr`/`oprnd` nibbles and `program_byte`, runs a fetch/execute/address state machine, and keeps the accumulator, carry/zero flags and output register. It drives the upstream block's counter-enable, fetch-enable, load and 12-bit load-address inputs, closing the fetch loop.

## Interface
- `RST_ACC` — default 4'h0 — accumulator and output-register value after reset.
- `clk` — in — 1 — single clock; all state updates on rising edge.
- `reset` — in — 1 — synchronous, active-high.
- `enable` — in — 1 — run; when low the FSM and all registers hold, and all strobes are 0.
- `instr` — in — 4 — opcode nibble from the fetch register.
- `oprnd` — in — 4 — operand nibble from the fetch register.
- `program_byte` — in — 8 — full fetch-register byte; jump low address byte.
- `data_in` — in — 4 — input bus, read by IN.
- `pc_en` — out — 1 — counter increment strobe (upstream En1).
- `fetch_en` — out — 1 — fetch-register capture strobe (upstream En2).
- `pc_load` — out — 1 — counter load strobe (upstream load).
- `pc_d` — out — 12 — load address (upstream D).
- `accu` — out — 4 — accumulator.
- `c_flag`, `z_flag` — out — 1 each — carry and zero flags.
- `out_reg` — out — 4 — output port register.
- `phase` — out — 1 — 0 in FETCH, 1 in EXEC or ADDR.
- `halted` — out — 1 — set by HLT.

## Operation
- States: FETCH, EXEC, ADDR, HALT. Reset state is FETCH.
- **FETCH:** `pc_en`=`fetch_en`=1. Go to EXEC.
- **EXEC:** decode `instr` and act as listed below.
  - 0 NOP: no change.
  - 1 LIT: A←oprnd.
  - 2 ADD: {C,A}←A+oprnd (5-bit sum); Z←(A==0).
  - 3 SUB: A←A−oprnd mod 16; C←(A≥oprnd), i.e. no borrow; Z←(result==0).
  - 4 AND, 5 OR, E XOR: A←A op oprnd; Z updated; C unchanged.
  - 6 IN: A←data_in; Z updated.
  - 7 OUT: out_reg←A.
  - D CMP: flags as SUB; A unchanged.
  - 8 JMP, 9 JC, A JNC, B JZ, C JNZ: latch oprnd into an internal address-high register; assert `pc_en`=`fetch_en`=1 to fetch the address byte; go to ADDR.
  - F HLT: go to HALT.
  - All other opcodes return to FETCH.
- **ADDR:** evaluate the condition on current flags; JMP is always taken.
  - Taken: `pc_load`=1 and `pc_d`={addr_hi, program_byte}.
  - Not taken: no strobe; the counter already points past the address byte.
  - Go to FETCH.
- **HALT:** all strobes 0; `halted`=1. Leave only through reset.
- Flags are modified only by ADD, SUB, AND, OR, XOR, IN and CMP. Jumps never modify flags.

## Timing
- Reset values: state FETCH; `accu`=`out_reg`=RST_ACC; C=Z=0; `halted`=0; `phase`=0; all strobes 0; `pc_d`=0.
- Strobes are combinational from state and are 0 while `reset` is high.
- Register results (A, flags, out_reg) become visible on the edge that ends EXEC.
- Instruction latency: 2 cycles for non-jumps; 3 cycles for jumps, taken or not.
- The upstream block gives load priority over increment. `pc_en` is never asserted together with `pc_load`.
- `enable` low in any state freezes state and registers; strobes are 0 and resume when `enable` returns high. In HALT, `enable` has no effect.
- Reset mid-instruction, including in ADDR: discard the pending jump and go to FETCH with reset values. No `pc_load` is issued in the reset cycle.
- `pc_d` holds its last value when `pc_load`=0.

## Test plan
- Reset, then LIT 9 followed by ADD 9 → `accu`=2, C=1, Z=0. Each instruction spans 2 cycles with `pc_en`/`fetch_en` high in FETCH only.
- LIT 3, SUB 3 → `accu`=0, C=1, Z=1. Then CMP 5 with A=0 → C=0, Z=0, `accu` stays 0.
- Z=1, JZ with oprnd=4 and address byte 8'h21 → in ADDR, `pc_load`=1 and `pc_d`=12'h421 for exactly one cycle, then FETCH.
- Z=1, JNZ → 3 cycles, no `pc_load`, flags unchanged.
- IN with `data_in`=4'hA, then OUT → `out_reg`=4'hA. Then HLT → `halted`=1 and no strobes for 10 cycles, including with `enable` toggling.
- `enable`=0 during EXEC of ADD → no register change while low; the instruction completes after re-enable. Reset asserted in ADDR of JMP → no `pc_load`, all outputs return to reset values, next cycle is FETCH.
